// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one Avalon-style memory port between the instruction-fetch requester
// (I) and the load/store requester (D). D has fixed priority because it belongs
// to the instruction already in flight. Each transfer is sequenced as
// IDLE -> XFER_* -> ACK -> IDLE.
//
// Bus outputs are registered and held stable through waitrequest stalls. Read
// data is captured on completion and returned with a one-cycle ack. A wait-cycle
// watchdog aborts a hung transfer. On abort it still acks the requester with
// zeroed data and raises a sticky timeout flag.
//
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   i_req/i_addr                    fetch request (level, held until i_ack)
//   i_ack/i_rdata                   fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata/d_byteen
//                                   load/store request (level, held until d_ack)
//   d_ack/d_rdata                   data completion pulse and load data
//   bus_address/bus_read/bus_write/bus_byteen/bus_wdata
//                                   registered memory command
//   bus_rdata/bus_wait              memory read data and waitrequest
//   busy                            1 whenever not in IDLE
//   timeout_err                     sticky watchdog-abort flag, cleared by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                reset,
  // instruction-fetch requester
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  // load/store requester
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteen,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  // memory bus
  output logic [ADDR_W-1:0]   bus_address,
  output logic                bus_read,
  output logic                bus_write,
  output logic [DATA_W/8-1:0] bus_byteen,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_wait,
  // status
  output logic                busy,
  output logic                timeout_err
);

  localparam int BE_W = DATA_W / 8;
  // The counter only has to reach MAX_WAIT-1, because the abort fires there.
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER_I = 2'd1,
    XFER_D = 2'd2,
    ACK    = 2'd3
  } state_e;

  state_e             state_q,       state_d;
  logic [ADDR_W-1:0]  bus_address_q, bus_address_d;
  logic               bus_read_q,    bus_read_d;
  logic               bus_write_q,   bus_write_d;
  logic [BE_W-1:0]    bus_byteen_q,  bus_byteen_d;
  logic [DATA_W-1:0]  bus_wdata_q,   bus_wdata_d;
  logic [DATA_W-1:0]  i_rdata_q,     i_rdata_d;
  logic [DATA_W-1:0]  d_rdata_q,     d_rdata_d;
  logic               i_ack_q,       i_ack_d;
  logic               d_ack_q,       d_ack_d;
  logic [CNT_W-1:0]   wait_cnt_q,    wait_cnt_d;
  logic               timeout_err_q, timeout_err_d;

  logic xfer_is_d;
  logic abort;

  assign xfer_is_d = (state_q == XFER_D);
  assign abort     = bus_wait && (wait_cnt_q == CNT_LAST);

  // NOTE: every *_d starts from a default (hold, or 0 for the ack pulses).
  // Without these defaults, any path through the case that skips a signal
  // would infer a latch.
  always_comb begin
    state_d       = state_q;
    bus_address_d = bus_address_q;
    bus_read_d    = bus_read_q;
    bus_write_d   = bus_write_q;
    bus_byteen_d  = bus_byteen_q;
    bus_wdata_d   = bus_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_ack_d       = 1'b0;
    d_ack_d       = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (d_req) begin
          bus_address_d = d_addr;
          bus_wdata_d   = d_wdata;
          bus_byteen_d  = d_byteen;
          bus_write_d   = d_we;
          bus_read_d    = ~d_we;
          state_d       = XFER_D;
        end else if (i_req) begin
          bus_address_d = i_addr;
          bus_wdata_d   = '0;
          bus_byteen_d  = '1;
          bus_write_d   = 1'b0;
          bus_read_d    = 1'b1;
          state_d       = XFER_I;
        end
      end

      XFER_I, XFER_D: begin
        if (bus_wait && !abort) begin
          // Stall: the bus registers hold by default; only the watchdog moves.
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
          // Either completion (bus_wait=0) or watchdog abort. In both cases the
          // strobes drop, the requester is acked, and the FSM moves to ACK.
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          wait_cnt_d  = '0;
          state_d     = ACK;
          if (xfer_is_d) d_ack_d = 1'b1;
          else           i_ack_d = 1'b1;
          if (abort) begin
            timeout_err_d = 1'b1;
            if (xfer_is_d) d_rdata_d = '0;
            else           i_rdata_d = '0;
          end else if (bus_read_q) begin
            if (xfer_is_d) d_rdata_d = bus_rdata;
            else           i_rdata_d = bus_rdata;
          end
        end
      end

      ACK: begin
        // Requests are deliberately not sampled here.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the read-data holding registers are reset along with everything
  // else. They are plain flops, not a memory array, and the outputs must read
  // 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      bus_address_q <= '0;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_byteen_q  <= '0;
      bus_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the
      // pre-edge value of the others.
      state_q       <= state_d;
      bus_address_q <= bus_address_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      bus_byteen_q  <= bus_byteen_d;
      bus_wdata_q   <= bus_wdata_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus_address = bus_address_q;
  assign bus_read    = bus_read_q;
  assign bus_write   = bus_write_q;
  assign bus_byteen  = bus_byteen_q;
  assign bus_wdata   = bus_wdata_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Transaction-level bench for mem_port_arbiter (MAX_WAIT=4). The bench drives
// the requesters and plays the memory, which stalls each strobe for a chosen
// number of cycles. Expectations come from the transfer rules:
//   - D before I.
//   - A strobe lasts min(waits+1, MAX_WAIT) cycles.
//   - Abort when waits >= MAX_WAIT.
//   - The ack comes one cycle after the last strobe cycle.
//   - The fabric is back in IDLE one cycle after the ack.
// Outputs are sampled on the falling edge, and inputs change there too.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_byteen;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] bus_address;
  logic              bus_read;
  logic              bus_write;
  logic [3:0]        bus_byteen;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_wait;
  logic              busy;
  logic              timeout_err;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteen(d_byteen), .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_wait(bus_wait), .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what each requester last received, plus the sticky flag.
  logic [DATA_W-1:0] exp_i_rd;
  logic [DATA_W-1:0] exp_d_rd;
  logic              exp_tmo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Serves one transfer, starting from the falling edge of the IDLE cycle in
  // which the request is visible. Returns at the falling edge of the IDLE
  // cycle that follows the ack.
  task automatic serve(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int k, input logic [31:0] rd);
    bit aborted;
    int n;
    bit is_read;
    aborted = (k >= MAX_WAIT);
    n       = aborted ? MAX_WAIT : k + 1;
    is_read = is_d ? !we : 1'b1;

    @(negedge clk);
    for (int c = 0; c < n; c++) begin
      check("bus_read",  bus_read,    is_read);
      check("bus_write", bus_write,   !is_read);
      check("bus_addr",  bus_address, addr);
      check("bus_be",    bus_byteen,  is_d ? be : 4'hF);
      check("bus_wdata", bus_wdata,   is_d ? wd : 32'h0);
      check("busy_x",    busy,        1'b1);
      check("no_ack_x",  {i_ack, d_ack}, 2'b00);
      bus_wait  = (c < k);
      bus_rdata = (c < k) ? $urandom : rd;
      // While busy, changes on the in-flight requester's inputs must be ignored.
      if (is_d) begin
        d_addr   = $urandom;
        d_wdata  = $urandom;
        d_byteen = 4'($urandom);
        d_we     = 1'($urandom);
      end else begin
        i_addr = $urandom;
      end
      @(negedge clk);
    end
    bus_wait  = 1'b0;
    bus_rdata = $urandom;

    if (aborted) begin
      exp_tmo = 1'b1;
      if (is_d) exp_d_rd = '0; else exp_i_rd = '0;
    end else if (is_read) begin
      if (is_d) exp_d_rd = rd; else exp_i_rd = rd;
    end

    // ACK cycle
    check("i_ack",      i_ack,       !is_d);
    check("d_ack",      d_ack,       is_d);
    check("strobe_ack", {bus_read, bus_write}, 2'b00);
    check("busy_ack",   busy,        1'b1);
    check("i_rdata",    i_rdata,     exp_i_rd);
    check("d_rdata",    d_rdata,     exp_d_rd);
    check("timeout",    timeout_err, exp_tmo);
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
    @(negedge clk);

    // IDLE cycle
    check("busy_idle",   busy,           1'b0);
    check("no_ack_idle", {i_ack, d_ack}, 2'b00);
    check("strobe_idle", {bus_read, bus_write}, 2'b00);
  endtask

  task automatic run_group(input bit use_i, input bit use_d, input logic [31:0] ia,
                           input bit dwe, input logic [31:0] da, input logic [31:0] dwd,
                           input logic [3:0] dbe, input int ki, input int kd,
                           input logic [31:0] rdi, input logic [31:0] rdd);
    i_req    = use_i;
    i_addr   = ia;
    d_req    = use_d;
    d_we     = dwe;
    d_addr   = da;
    d_wdata  = dwd;
    d_byteen = dbe;
    if (use_d) serve(1'b1, dwe, da, dwd, dbe, kd, rdd);
    if (use_i) serve(1'b0, 1'b0, ia, 32'h0, 4'hF, ki, rdi);
    if (!use_i && !use_d) begin
      @(negedge clk);
      check("idle_strobe", {bus_read, bus_write}, 2'b00);
      check("idle_busy",   busy, 1'b0);
    end
  endtask

  function automatic int rand_k();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(MAX_WAIT, MAX_WAIT + 1));
    return int'($urandom_range(0, MAX_WAIT - 1));
  endfunction

  initial begin
    exp_i_rd = '0;
    exp_d_rd = '0;
    exp_tmo  = 1'b0;
    reset    = 1'b0;
    i_req    = 1'b1;
    d_req    = 1'b1;
    i_addr   = 32'hBFC0_0000;
    d_we     = 1'b1;
    d_addr   = 32'h0000_1000;
    d_wdata  = 32'hDEAD_BEEF;
    d_byteen = 4'b0011;
    bus_wait = 1'b0;
    bus_rdata = 32'h0;

    // Reset held with both requests asserted: everything stays 0.
    repeat (3) @(negedge clk);
    check("rst_outputs",
          {bus_address, bus_read, bus_write, bus_byteen, bus_wdata},
          {32'h0, 1'b0, 1'b0, 4'h0, 32'h0});
    check("rst_acks",  {i_ack, d_ack}, 2'b00);
    check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    check("rst_busy",  busy, 1'b0);
    check("rst_tmo",   timeout_err, 1'b0);
    reset = 1'b1;

    // Simultaneous requests: the D write goes first, then the I fetch.
    run_group(1'b1, 1'b1, 32'hBFC0_0000, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011,
              0, 0, 32'h2402_0005, 32'h0);

    // Plain fetch with no wait states.
    run_group(1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0, 4'h0,
              0, 0, 32'h2402_0005, 32'h0);

    // D load to 0x2000 with three wait cycles.
    run_group(1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_2000, 32'h0, 4'hF,
              0, 3, 32'h0, 32'hCAFE_F00D);

    // Watchdog: waitrequest stuck high; the transfer aborts, then the next
    // request proceeds normally.
    run_group(1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_3000, 32'h0, 4'hF,
              0, MAX_WAIT + 3, 32'h0, 32'h1111_2222);
    run_group(1'b1, 1'b0, 32'h0000_0040, 1'b0, 32'h0, 32'h0, 4'h0,
              0, 1, 32'h3333_4444, 32'h0);

    // Randomised traffic.
    for (int g = 0; g < 150; g++) begin
      run_group(1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
                4'($urandom), rand_k(), rand_k(), $urandom, $urandom);
    end

    // Reset in the middle of a stalled D write.
    i_req    = 1'b0;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 32'h0000_4000;
    d_wdata  = 32'h5555_AAAA;
    d_byteen = 4'hF;
    bus_wait = 1'b1;
    @(negedge clk);
    check("mid_write_up", bus_write, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_write_drop", bus_write, 1'b0);
    check("mid_busy",       busy, 1'b0);
    check("mid_tmo_clr",    timeout_err, 1'b0);
    d_req    = 1'b0;
    bus_wait = 1'b0;
    exp_i_rd = '0;
    exp_d_rd = '0;
    exp_tmo  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_no_ack", {i_ack, d_ack}, 2'b00);
    end

    // A normal transfer works after that reset.
    run_group(1'b1, 1'b0, 32'h0000_0080, 1'b0, 32'h0, 32'h0, 4'h0,
              2, 0, 32'h7777_8888, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  // Global safety net so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "bench timeout");
  end

endmodule
